// File: rtl/if_stage_pkg.sv
// Shared types and constants for the fetch stage
// and the IF/ID pipeline register.
package if_stage_pkg;

  localparam int MR_INSTR_W = 16;

  localparam logic [MR_INSTR_W-1:0] MR_RESET_PC  = 16'h0000;
  localparam logic [MR_INSTR_W-1:0] MR_NOP_INSTR = 16'h0000;

  typedef logic [MR_INSTR_W-1:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t pc_plus1;
    logic  valid;
  } if_id_t;

  // Modulo 2^16 increment; FFFF wraps to 0000.
  function automatic word_t pc_inc(input word_t a);
    return a + word_t'(1);
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with rst > flush > stall > load priority.
// Anything not loaded becomes a bubble.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter word_t NOP_INSTR = MR_NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_i,
  input  logic   flush_i,
  input  logic   stall_i,
  input  logic   load_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      q_q.instr    <= NOP_INSTR;
      q_q.pc       <= '0;
      q_q.pc_plus1 <= '0;
      q_q.valid    <= 1'b0;
    end else if (flush_i) begin
      q_q.instr <= NOP_INSTR;
      q_q.valid <= 1'b0;
    end else if (stall_i) begin
      q_q <= q_q;
    end else if (load_i) begin
      q_q <= d_i;
    end else begin
      q_q.instr <= NOP_INSTR;
      q_q.valid <= 1'b0;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding imem requests,
// stall hold buffer and stale-request drop after redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter word_t RESET_PC  = MR_RESET_PC,
  parameter word_t NOP_INSTR = MR_NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  stall,
  input  logic  flush,
  input  logic  redirect_valid,
  input  word_t redirect_pc,
  output logic  imem_req,
  output word_t imem_addr,
  input  logic  imem_ack,
  input  word_t imem_rdata,
  output word_t instruction,
  output word_t pc,
  output word_t pc_plus1,
  output logic  valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_DROP = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e state_q, state_d;
  word_t  fetch_pc_q, fetch_pc_d;
  word_t  drop_addr_q, drop_addr_d;
  word_t  hold_instr_q, hold_instr_d;
  word_t  hold_pc_q, hold_pc_d;

  logic   load;
  if_id_t if_id_d;
  if_id_t if_id_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drop_addr_d  = drop_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    load         = 1'b0;
    if_id_d.instr    = imem_rdata;
    if_id_d.pc       = fetch_pc_q;
    if_id_d.pc_plus1 = pc_inc(fetch_pc_q);
    if_id_d.valid    = 1'b1;
    unique case (state_q)
      S_REQ: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
          end else if (!flush) begin
            fetch_pc_d = pc_inc(fetch_pc_q);
            if (stall) begin
              hold_instr_d = imem_rdata;
              hold_pc_d    = fetch_pc_q;
              state_d      = S_HOLD;
            end else begin
              load = 1'b1;
            end
          end
        end else if (redirect_valid) begin
          drop_addr_d = fetch_pc_q;
          fetch_pc_d  = redirect_pc;
          state_d     = S_DROP;
        end
      end
      S_DROP: begin
        if (redirect_valid) fetch_pc_d = redirect_pc;
        if (imem_ack) state_d = S_REQ;
      end
      S_HOLD: begin
        if_id_d.instr    = hold_instr_q;
        if_id_d.pc       = hold_pc_q;
        if_id_d.pc_plus1 = pc_inc(hold_pc_q);
        if (redirect_valid || flush) begin
          // Without a redirect, refetch the discarded buffered word.
          fetch_pc_d = redirect_valid ? redirect_pc : hold_pc_q;
          state_d    = S_REQ;
        end else if (!stall) begin
          load    = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      drop_addr_q  <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drop_addr_q  <= drop_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  assign imem_req  = !rst && (state_q == S_REQ || state_q == S_DROP);
  assign imem_addr = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk    (clk),
    .rst_i  (rst),
    .flush_i(flush),
    .stall_i(stall),
    .load_i (load),
    .d_i    (if_id_d),
    .q_o    (if_id_q)
  );

  assign instruction = if_id_q.instr;
  assign pc          = if_id_q.pc;
  assign pc_plus1    = if_id_q.pc_plus1;
  assign valid       = if_id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage: table of per-cycle stimulus
// with expected request and IF/ID contents, plus reset sequences.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instruction, pc, pc_plus1;
  logic        valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc            (pc),
    .pc_plus1      (pc_plus1),
    .valid         (valid)
  );

  typedef struct {
    logic        st;
    logic        fl;
    logic        rv;
    logic [15:0] rpc;
    logic        ack;
    logic        req;
    logic [15:0] addr;
    logic        v;
    logic [15:0] pc;
    logic [15:0] ins;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic st, fl, rv, input logic [15:0] rpc,
    input logic ack, req, input logic [15:0] addr,
    input logic v, input logic [15:0] epc, ins);
    vec_t r;
    r.st = st; r.fl = fl; r.rv = rv; r.rpc = rpc;
    r.ack = ack; r.req = req; r.addr = addr;
    r.v = v; r.pc = epc; r.ins = ins;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 0; flush = 0; redirect_valid = 0;
    redirect_pc = '0; imem_ack = 0; imem_rdata = '0;

    // zero-wait stream
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'h0000, 1,16'h0000,16'hA500));
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'h0001, 1,16'h0001,16'hA501));
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'h0002, 1,16'h0002,16'hA502));
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'h0003, 1,16'h0003,16'hA503));
    // two-cycle latency
    vecs.push_back(mk(0,0,0,16'h0,0, 1,16'h0004, 0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'h0004, 1,16'h0004,16'hA504));
    // stall on ack of 5
    vecs.push_back(mk(1,0,0,16'h0,1, 1,16'h0005, 1,16'h0004,16'hA504));
    vecs.push_back(mk(1,0,0,16'h0,0, 0,16'h0000, 1,16'h0004,16'hA504));
    vecs.push_back(mk(1,0,0,16'h0,0, 0,16'h0000, 1,16'h0004,16'hA504));
    vecs.push_back(mk(0,0,0,16'h0,0, 0,16'h0000, 1,16'h0005,16'hA505));
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'h0006, 1,16'h0006,16'hA506));
    // flush+redirect while 7 is pending
    vecs.push_back(mk(0,1,1,16'h40,0, 1,16'h0007, 0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0,0, 1,16'h0007, 0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'h0007, 0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'h0040, 1,16'h0040,16'hA540));
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'h0041, 1,16'h0041,16'hA541));
    // redirect while holding
    vecs.push_back(mk(1,0,0,16'h0,1, 1,16'h0042, 1,16'h0041,16'hA541));
    vecs.push_back(mk(1,0,1,16'h100,0, 0,16'h0000, 1,16'h0041,16'hA541));
    vecs.push_back(mk(1,0,0,16'h0,0, 1,16'h0100, 1,16'h0041,16'hA541));
    vecs.push_back(mk(0,1,0,16'h0,0, 1,16'h0100, 0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'h0100, 1,16'h0100,16'hA400));
    // redirect to FFFF with ack, then wrap
    vecs.push_back(mk(0,0,1,16'hFFFF,1, 1,16'h0101, 0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'hFFFF, 1,16'hFFFF,16'h5AFF));
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'h0000, 1,16'h0000,16'hA500));
    // flush-only on ack refetches the same word
    vecs.push_back(mk(0,1,0,16'h0,1, 1,16'h0001, 0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'h0001, 1,16'h0001,16'hA501));
    // redirect, second redirect while dropping
    vecs.push_back(mk(0,0,1,16'h200,0, 1,16'h0002, 0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,1,16'h300,0, 1,16'h0002, 0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'h0002, 0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0,1, 1,16'h0300, 1,16'h0300,16'hA600));

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", 0, {15'd0, imem_req}, 16'd0);
    chk("rst_valid", 0, {15'd0, valid}, 16'd0);
    chk("rst_instr", 0, instruction, 16'h0000);
    chk("rst_pc", 0, pc, 16'h0000);
    chk("rst_pc1", 0, pc_plus1, 16'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst            = 1'b0;
      stall          = vecs[i].st;
      flush          = vecs[i].fl;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      imem_ack       = vecs[i].ack;
      imem_rdata     = vecs[i].addr ^ 16'hA500;
      #1;
      chk("req", i, {15'd0, imem_req}, {15'd0, vecs[i].req});
      if (vecs[i].req) chk("addr", i, imem_addr, vecs[i].addr);
      @(posedge clk); #1;
      chk("valid", i, {15'd0, valid}, {15'd0, vecs[i].v});
      chk("instr", i, instruction, vecs[i].ins);
      if (vecs[i].v) begin
        chk("pc", i, pc, vecs[i].pc);
        chk("pc_plus1", i, pc_plus1, vecs[i].pc + 16'd1);
      end
    end

    // reset while a request to 0x301 is outstanding
    @(negedge clk);
    stall = 0; flush = 0; redirect_valid = 0; imem_ack = 0;
    #1;
    chk("mid_req", 100, {15'd0, imem_req}, 16'd1);
    chk("mid_addr", 100, imem_addr, 16'h0301);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 101, {15'd0, imem_req}, 16'd0);
    @(posedge clk); #1;
    chk("mid_rst_valid", 101, {15'd0, valid}, 16'd0);
    chk("mid_rst_pc", 101, pc, 16'h0000);
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h0000 ^ 16'hA500;
    #1;
    chk("restart_req", 102, {15'd0, imem_req}, 16'd1);
    chk("restart_addr", 102, imem_addr, 16'h0000);
    @(posedge clk); #1;
    chk("restart_valid", 102, {15'd0, valid}, 16'd1);
    chk("restart_pc", 102, pc, 16'h0000);
    chk("restart_instr", 102, instruction, 16'hA500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
